ones_frame_accumulator: RTL and testbench



---
 rtl/ones_frame_pkg.sv | 19 +
 rtl/ones_frame_wcnt.sv | 23 ++
 rtl/ones_frame_accumulator.sv | 132 +++++++++++++
 tb/tb_ones_frame_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ones_frame_pkg.sv
// Shared types and constants for the ones-count frame accumulator.
// Holds the FSM state encoding and the count sanitising helper.
package ones_frame_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int COUNT_W   = 6;
  localparam int MAX_COUNT = 32;
  localparam int MIN_INIT  = 63;

  // Counts above 32 cannot come from a 32-bit word; treat them as 32.
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] c);
    return (c > COUNT_W'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : c;
  endfunction

endpackage

// File: rtl/ones_frame_wcnt.sv
// Modulo-FRAME_WORDS word counter; 'last' flags the final word slot of a frame.
module ones_frame_wcnt #(
  parameter int FRAME_WORDS = 16,
  parameter int WCNT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [WCNT_W-1:0] wcnt,
  output logic              last
);

  assign last = (wcnt == WCNT_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (inc) begin
      wcnt <= last ? '0 : wcnt + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Accumulates FRAME_WORDS ones-counts into a frame total with min/max/err stats.
// Min/max tracking is built only when ONES_FRAME_MINMAX_EN is defined.
module ones_frame_accumulator
  import ones_frame_pkg::*;
#(
  parameter int FRAME_WORDS = 16,
  parameter int ACC_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COUNT_W-1:0] in_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_total,
  output logic [COUNT_W-1:0] out_min,
  output logic [COUNT_W-1:0] out_max,
  output logic               out_err
);

  localparam int WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  if (FRAME_WORDS < 1 || FRAME_WORDS > 1024) begin : g_bad_frame_words
    $error("ones_frame_accumulator: FRAME_WORDS must be in 1..1024");
  end
  if (ACC_W < COUNT_W + $clog2(FRAME_WORDS)) begin : g_bad_acc_w
    $error("ones_frame_accumulator: ACC_W too narrow for 32*FRAME_WORDS");
  end

  state_t             state, state_nxt;
  logic [WCNT_W-1:0]  wcnt;
  logic               last;
  logic               accept, take;
  logic               over;
  logic [COUNT_W-1:0] cnt_c;
  logic [ACC_W-1:0]   acc, sum_nxt;
  logic               rerr, err_nxt;

  assign in_ready  = !rst && ((state == ACC) || (state == HOLD && out_ready));
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  assign over    = (in_count > COUNT_W'(MAX_COUNT));
  assign cnt_c   = clamp_count(in_count);
  assign sum_nxt = acc + ACC_W'(cnt_c);
  assign err_nxt = rerr || over;

  ones_frame_wcnt #(
    .FRAME_WORDS (FRAME_WORDS),
    .WCNT_W      (WCNT_W)
  ) u_wcnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .wcnt (wcnt),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // A consumed result with a simultaneously completed frame (FRAME_WORDS=1) stays in HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC: begin
        if (accept && last) state_nxt = HOLD;
      end
      HOLD: begin
        if (take) state_nxt = (accept && last) ? HOLD : ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Running registers return to neutral values at frame end so the next word loads cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      rerr      <= 1'b0;
      out_total <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      if (last) begin
        out_total <= sum_nxt;
        out_err   <= err_nxt;
        acc       <= '0;
        rerr      <= 1'b0;
      end else begin
        acc  <= sum_nxt;
        rerr <= err_nxt;
      end
    end
  end

`ifdef ONES_FRAME_MINMAX_EN
  logic [COUNT_W-1:0] rmin, rmax, min_nxt, max_nxt;

  assign min_nxt = (cnt_c < rmin) ? cnt_c : rmin;
  assign max_nxt = (cnt_c > rmax) ? cnt_c : rmax;

  always_ff @(posedge clk) begin
    if (rst) begin
      rmin    <= COUNT_W'(MIN_INIT);
      rmax    <= '0;
      out_min <= '0;
      out_max <= '0;
    end else if (accept) begin
      if (last) begin
        out_min <= min_nxt;
        out_max <= max_nxt;
        rmin    <= COUNT_W'(MIN_INIT);
        rmax    <= '0;
      end else begin
        rmin <= min_nxt;
        rmax <= max_nxt;
      end
    end
  end
`else
  assign out_min = '0;
  assign out_max = '0;
`endif

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Scoreboard bench: drives one FRAME_WORDS=4 and one FRAME_WORDS=1 accumulator from
// shared stimulus, with an independent per-instance model of the frame statistics.
module tb_ones_frame_accumulator;

`ifdef ONES_FRAME_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  typedef struct {
    int total;
    int mn;
    int mx;
    int err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_count;
  logic       out_ready;

  logic        ir   [2];
  logic        ov   [2];
  logic [15:0] tot  [2];
  logic [5:0]  omin [2];
  logic [5:0]  omax [2];
  logic        oerr [2];

  int checks = 0;
  int errors = 0;

  int m_fw [2] = '{4, 1};
  bit m_hold [2];
  int m_wcnt [2];
  int m_acc  [2];
  int m_min  [2];
  int m_max  [2];
  int m_err  [2];
  exp_t q0 [$];
  exp_t q1 [$];

  ones_frame_accumulator #(.FRAME_WORDS(4), .ACC_W(16)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ir[0]),
    .in_count  (in_count),
    .out_valid (ov[0]),
    .out_ready (out_ready),
    .out_total (tot[0]),
    .out_min   (omin[0]),
    .out_max   (omax[0]),
    .out_err   (oerr[0])
  );

  ones_frame_accumulator #(.FRAME_WORDS(1), .ACC_W(16)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ir[1]),
    .in_count  (in_count),
    .out_valid (ov[1]),
    .out_ready (out_ready),
    .out_total (tot[1]),
    .out_min   (omin[1]),
    .out_max   (omax[1]),
    .out_err   (oerr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void model_clear(input int k);
    m_wcnt[k] = 0;
    m_acc[k]  = 0;
    m_min[k]  = 63;
    m_max[k]  = 0;
    m_err[k]  = 0;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) checkOutput($sformatf("dut%0d.in_ready_in_reset", k), int'(ir[k]), 0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d.rst_out_valid", k), int'(ov[k]), 0);
      checkOutput($sformatf("dut%0d.rst_total", k), int'(tot[k]), 0);
      checkOutput($sformatf("dut%0d.rst_min", k), int'(omin[k]), 0);
      checkOutput($sformatf("dut%0d.rst_max", k), int'(omax[k]), 0);
      checkOutput($sformatf("dut%0d.rst_err", k), int'(oerr[k]), 0);
      m_hold[k] = 1'b0;
      model_clear(k);
    end
    q0.delete();
    q1.delete();
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic applyStimulus(input logic v, input int c, input logic ordy);
    exp_t e;
    bit   rdy;
    bit   take;
    int   cc;
    @(negedge clk);
    in_valid = v; in_count = 6'(c); out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy = !m_hold[k] || ordy;
      checkOutput($sformatf("dut%0d.in_ready", k), int'(ir[k]), int'(rdy));
      checkOutput($sformatf("dut%0d.out_valid", k), int'(ov[k]), int'(m_hold[k]));
      if (m_hold[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          checkOutput($sformatf("dut%0d.scoreboard_empty", k), 1, 0);
        end else begin
          e = (k == 0) ? q0[0] : q1[0];
          checkOutput($sformatf("dut%0d.out_total", k), int'(tot[k]), e.total);
          checkOutput($sformatf("dut%0d.out_min", k), int'(omin[k]), MINMAX ? e.mn : 0);
          checkOutput($sformatf("dut%0d.out_max", k), int'(omax[k]), MINMAX ? e.mx : 0);
          checkOutput($sformatf("dut%0d.out_err", k), int'(oerr[k]), e.err);
        end
      end
      take = m_hold[k] && ordy;
      if (take) begin
        if (k == 0 && q0.size() > 0) void'(q0.pop_front());
        if (k == 1 && q1.size() > 0) void'(q1.pop_front());
        m_hold[k] = 1'b0;
      end
      if (v && rdy) begin
        cc = (c > 32) ? 32 : c;
        m_acc[k] += cc;
        if (cc < m_min[k]) m_min[k] = cc;
        if (cc > m_max[k]) m_max[k] = cc;
        if (c > 32) m_err[k] = 1;
        if (m_wcnt[k] == m_fw[k] - 1) begin
          e.total = m_acc[k]; e.mn = m_min[k]; e.mx = m_max[k]; e.err = m_err[k];
          if (k == 0) q0.push_back(e); else q1.push_back(e);
          m_hold[k] = 1'b1;
          model_clear(k);
        end else begin
          m_wcnt[k]++;
        end
      end
    end
  endtask

  task automatic sendFrame(input int a, input int b, input int c, input int d, input logic ordy);
    applyStimulus(1'b1, a, ordy);
    applyStimulus(1'b1, b, ordy);
    applyStimulus(1'b1, c, ordy);
    applyStimulus(1'b1, d, ordy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    doReset();

    // Basic frame with a boundary count of 32 and a zero.
    sendFrame(3, 32, 0, 7, 1'b1);
    idle(2);

    // Backpressure: result held for five cycles, then consumed alongside a new word.
    sendFrame(3, 32, 0, 7, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9, 1'b0);
    applyStimulus(1'b1, 9, 1'b1);
    applyStimulus(1'b1, 9, 1'b1);
    applyStimulus(1'b1, 9, 1'b1);
    applyStimulus(1'b1, 9, 1'b1);
    idle(2);

    // Out-of-range count flags the frame; the next clean frame must not.
    sendFrame(10, 40, 10, 10, 1'b1);
    sendFrame(1, 2, 3, 4, 1'b1);
    idle(2);

    // Reset part-way through a frame, then a fresh frame.
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b1, 5, 1'b1);
    doReset();
    sendFrame(1, 1, 1, 1, 1'b1);
    idle(2);

    // Back-to-back words; the single-word instance emits one result per cycle.
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b1, 6, 1'b1);
    applyStimulus(1'b1, 7, 1'b1);
    idle(2);

    // Randomised traffic including illegal counts and sporadic backpressure.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(1)), int'($urandom_range(40)),
                    1'($urandom_range(3) != 0));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
